// File: rtl/bw_clk_seq_pkg.sv
// bw_clk_seq_pkg: state encodings, per-state output decode and stop-counter limit for the sctag clock sequencer
package bw_clk_seq_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_CKEN_WAIT = 3'd1;
  localparam state_t S_RST_HOLD  = 3'd2;
  localparam state_t S_RUN       = 3'd3;
  localparam state_t S_DBG_HOLD  = 3'd4;
  localparam state_t S_STOP      = 3'd5;
  localparam state_t S_RESTART   = 3'd6;
  // {cken, grst_l, gdbginit_l, stop_ack} indexed by state; 111 decodes like IDLE
  localparam logic [7:0][3:0] OUT_DEC = {4'b0000, 4'b0110, 4'b0111, 4'b1100,
                                         4'b1110, 4'b1000, 4'b0000, 4'b0000};
  localparam logic [7:0] STOP_CNT_MAX = 8'hff;
endpackage

// File: rtl/bw_clk_seq_dly_cnt.sv
// bw_clk_seq_dly_cnt: loadable down-counter that holds at zero
// Ports: clk_i, rst_i (async, active-high), load_i, load_val_i [CNT_W-1:0], zero_o
module bw_clk_seq_dly_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/bw_clk_cl_sctag_seq.sv
// bw_clk_cl_sctag_seq: power-on / warm-reset / debug-init / clock-stop sequencer for the sctag cluster clock header
// Ports: gclk, arst (async, active-high); ccu_go, wrst_req, dbg_req, stop_req in;
//        cluster_cken, grst_l, gdbginit_l, stop_ack, seq_busy, seq_state[2:0] out.
// Define BW_CLK_SEQ_STOP_CNT_EN to add the saturating stop_cnt[7:0] output.
module bw_clk_cl_sctag_seq
  import bw_clk_seq_pkg::*;
#(
  parameter int CKEN_DLY = 4,
  parameter int RST_DLY  = 8,
  parameter int CNT_W    = 4
) (
  input  logic       gclk,
  input  logic       arst,
  input  logic       ccu_go,
  input  logic       wrst_req,
  input  logic       dbg_req,
  input  logic       stop_req,
  output logic       cluster_cken,
  output logic       grst_l,
  output logic       gdbginit_l,
  output logic       stop_ack,
  output logic       seq_busy,
  output logic [2:0] seq_state
`ifdef BW_CLK_SEQ_STOP_CNT_EN
  , output logic [7:0] stop_cnt
`endif
);
  localparam logic [CNT_W-1:0] CKEN_LD = CNT_W'(CKEN_DLY - 1);
  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_DLY - 1);
  localparam int MAX_DLY = (CKEN_DLY > RST_DLY) ? CKEN_DLY : RST_DLY;
  state_t state_q, state_d;
  logic [3:0] out_q, out_d;
  logic busy_q, busy_d, ld, zero;
  logic [CNT_W-1:0] ld_val;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = ccu_go ? S_CKEN_WAIT : S_IDLE;
      S_CKEN_WAIT: state_d = zero ? S_RST_HOLD : S_CKEN_WAIT;
      S_RST_HOLD:  state_d = zero ? S_RUN : S_RST_HOLD;
      S_RUN:       state_d = wrst_req ? S_RST_HOLD : stop_req ? S_STOP : dbg_req ? S_DBG_HOLD : S_RUN;
      S_DBG_HOLD:  state_d = wrst_req ? S_RST_HOLD : zero ? S_RUN : S_DBG_HOLD;
      S_STOP:      state_d = stop_req ? S_STOP : S_RESTART;
      S_RESTART:   state_d = zero ? S_RUN : S_RESTART;
      default:     state_d = S_IDLE;
    endcase
  end
  // every entry into a timed state is a state change, including DBG_HOLD -> RST_HOLD
  always_comb begin
    ld     = state_d != state_q && (state_d == S_CKEN_WAIT || state_d == S_RST_HOLD ||
                                    state_d == S_DBG_HOLD || state_d == S_RESTART);
    ld_val = (state_d == S_CKEN_WAIT || state_d == S_RESTART) ? CKEN_LD : RST_LD;
    out_d  = OUT_DEC[state_d];
    busy_d = !(state_d == S_RUN || state_d == S_STOP);
  end
  bw_clk_seq_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .clk_i      (gclk),
    .rst_i      (arst),
    .load_i     (ld),
    .load_val_i (ld_val),
    .zero_o     (zero)
  );
  always_ff @(posedge gclk or posedge arst)
    if (arst) begin
      state_q <= S_IDLE;
      out_q   <= 4'b0000;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  assign {cluster_cken, grst_l, gdbginit_l, stop_ack} = out_q;
  assign seq_busy  = busy_q;
  assign seq_state = state_q;
`ifdef BW_CLK_SEQ_STOP_CNT_EN
  logic [7:0] stop_cnt_q;
  always_ff @(posedge gclk or posedge arst)
    if (arst) stop_cnt_q <= 8'd0;
    else if (state_q == S_RUN && state_d == S_STOP && stop_cnt_q != STOP_CNT_MAX) stop_cnt_q <= stop_cnt_q + 8'd1;
  assign stop_cnt = stop_cnt_q;
`endif
  a_dly_fits: assert property (@(posedge gclk) MAX_DLY <= (1 << CNT_W));
endmodule

// File: tb/tb_bw_clk_cl_sctag_seq.sv
// tb_bw_clk_cl_sctag_seq: scoreboard bench for the sctag clock sequencer
module tb_bw_clk_cl_sctag_seq;
  // {cken, grst_l, gdbginit_l, stop_ack, seq_busy, seq_state}
  localparam logic [7:0] V_IDLE = 8'b0000_1_000;
  localparam logic [7:0] V_CKW  = 8'b0000_1_001;
  localparam logic [7:0] V_RSTH = 8'b1000_1_010;
  localparam logic [7:0] V_RUN  = 8'b1110_0_011;
  localparam logic [7:0] V_DBG  = 8'b1100_1_100;
  localparam logic [7:0] V_STOP = 8'b0111_0_101;
  localparam logic [7:0] V_RST  = 8'b0110_1_110;
  logic gclk, arst, ccu_go, wrst_req, dbg_req, stop_req;
  logic cluster_cken, grst_l, gdbginit_l, stop_ack, seq_busy;
  logic [2:0] seq_state;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  string name_q[$];
`ifdef BW_CLK_SEQ_STOP_CNT_EN
  logic [7:0] stop_cnt;
`endif
  bw_clk_cl_sctag_seq dut (
    .gclk         (gclk),
    .arst         (arst),
    .ccu_go       (ccu_go),
    .wrst_req     (wrst_req),
    .dbg_req      (dbg_req),
    .stop_req     (stop_req),
    .cluster_cken (cluster_cken),
    .grst_l       (grst_l),
    .gdbginit_l   (gdbginit_l),
    .stop_ack     (stop_ack),
    .seq_busy     (seq_busy),
    .seq_state    (seq_state)
`ifdef BW_CLK_SEQ_STOP_CNT_EN
    , .stop_cnt   (stop_cnt)
`endif
  );
  initial gclk = 1'b0;
  always #5 gclk = ~gclk;
  function automatic logic [7:0] got();
    return {cluster_cken, grst_l, gdbginit_l, stop_ack, seq_busy, seq_state};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask
  // inputs change on the falling edge; the expected post-edge outputs are queued
  task automatic step(input logic go, input logic w, input logic d, input logic s,
                      input logic [7:0] e, input string nm);
    @(negedge gclk);
    ccu_go = go; wrst_req = w; dbg_req = d; stop_req = s;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge gclk);
      n++;
    end
    #2;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask
  task automatic power_up();
    step(1, 0, 0, 0, V_CKW, "go");
    repeat (3) step(1, 0, 0, 0, V_CKW, "cken_wait");
    step(0, 1, 1, 0, V_RSTH, "cken_up");
    repeat (7) step(0, 0, 0, 0, V_RSTH, "rst_hold");
    step(0, 0, 0, 0, V_RUN, "run_entry");
  endtask
  // monitor: compares the oldest queued expectation just after each rising edge
  initial forever begin
    @(posedge gclk);
    #1;
    if (exp_q.size() != 0) chk(name_q.pop_front(), 32'(got()), 32'(exp_q.pop_front()));
  end
  initial begin
    arst = 1'b1; ccu_go = 0; wrst_req = 0; dbg_req = 0; stop_req = 0;
    repeat (2) @(posedge gclk);
    #1;
    chk("reset", 32'(got()), 32'(V_IDLE));
    @(negedge gclk) arst = 1'b0;
    step(0, 1, 1, 1, V_IDLE, "idle_drop");
    power_up();
    step(0, 0, 0, 0, V_RUN, "run_hold");
    step(0, 1, 0, 0, V_RSTH, "wrst");
    repeat (7) step(0, 0, 0, 0, V_RSTH, "wrst_hold");
    step(0, 0, 0, 0, V_RUN, "wrst_done");
    step(0, 0, 1, 0, V_DBG, "dbg");
    repeat (7) step(0, 0, 0, 0, V_DBG, "dbg_hold");
    step(0, 0, 0, 0, V_RUN, "dbg_done");
    step(0, 0, 1, 0, V_DBG, "dbg2");
    step(0, 0, 0, 0, V_DBG, "dbg2_hold");
    step(0, 0, 1, 0, V_DBG, "dbg_in_dbg_drop");
    step(0, 1, 0, 0, V_RSTH, "wrst_in_dbg");
    repeat (7) step(0, 0, 0, 0, V_RSTH, "wrst_fresh");
    step(0, 0, 0, 0, V_RUN, "wrst_fresh_done");
    step(0, 0, 0, 1, V_STOP, "stop");
    step(0, 1, 0, 1, V_STOP, "stop_wrst_drop");
    step(0, 0, 1, 1, V_STOP, "stop_dbg_drop");
    step(0, 0, 0, 0, V_RST, "restart");
    step(0, 1, 0, 0, V_RST, "restart_wrst_drop");
    repeat (2) step(0, 0, 0, 0, V_RST, "restart_hold");
    step(0, 0, 0, 0, V_RUN, "restart_done");
    step(0, 1, 0, 1, V_RSTH, "wrst_over_stop");
    repeat (7) step(0, 0, 0, 1, V_RSTH, "stop_ignored");
    step(0, 0, 0, 1, V_RUN, "prio_run");
    step(0, 0, 0, 1, V_STOP, "late_stop");
    step(0, 0, 0, 0, V_RST, "late_restart");
    repeat (3) step(0, 0, 0, 0, V_RST, "late_restart_hold");
    step(0, 0, 0, 0, V_RUN, "late_run");
    step(0, 1, 0, 0, V_RSTH, "pre_arst");
    step(0, 0, 0, 0, V_RSTH, "pre_arst_hold");
    drain();
    #2 arst = 1'b1;
    #1 chk("arst_async", 32'(got()), 32'(V_IDLE));
    @(negedge gclk) arst = 1'b0;
    step(0, 0, 1, 0, V_IDLE, "post_arst_idle");
    power_up();
    drain();
`ifdef BW_CLK_SEQ_STOP_CNT_EN
    repeat (260) begin
      step(0, 0, 0, 1, V_STOP, "sc_stop");
      step(0, 0, 0, 0, V_RST, "sc_restart");
      repeat (3) step(0, 0, 0, 0, V_RST, "sc_restart_hold");
      step(0, 0, 0, 0, V_RUN, "sc_run");
    end
    drain();
    chk("stop_cnt_sat", 32'(stop_cnt), 32'd255);
    #2 arst = 1'b1;
    #1 chk("stop_cnt_clr", 32'(stop_cnt), 32'd0);
    @(negedge gclk) arst = 1'b0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
